// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin-slot validator: synchronizer, pulse-width check, credit queue, gapped dispense
module coin_acceptor #(
   parameter int MIN_W      = 3,
   parameter int MAX_W      = 10,
   parameter int CREDIT_MAX = 15,
   parameter int GAP        = 1
)(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       sensor_i,
   input  logic       ready_i,
   output logic       coin_o,
   output logic       accept_o,
   output logic       reject_o,
   output logic       full_o,
   output logic [7:0] credit_o,
   output logic [7:0] total_o
);

   typedef enum logic [1:0] {M_IDLE, M_MEAS, M_JAM} meas_t;
   typedef enum logic {D_IDLE, D_WAIT} disp_t;

   logic       s1, s;
   meas_t      mstate;
   disp_t      dstate;
   logic [7:0] width;
   logic [3:0] gap;
   logic       dispense, width_ok, accept;

   assign dispense = (dstate == D_IDLE) && (credit_o != 8'd0) && ready_i;
   assign width_ok = (width >= 8'(MIN_W)) && (width <= 8'(MAX_W));
   // A full queue may still take a coin when a credit leaves on the same edge.
   assign accept   = (mstate == M_MEAS) && !s && width_ok &&
                     ((credit_o < 8'(CREDIT_MAX)) || dispense);
   assign full_o   = (credit_o == 8'(CREDIT_MAX));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1 <= 1'b0;
         s  <= 1'b0;
      end else begin
         s1 <= sensor_i;
         s  <= s1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mstate   <= M_IDLE;
         width    <= 8'd0;
         accept_o <= 1'b0;
         reject_o <= 1'b0;
      end else begin
         accept_o <= 1'b0;
         reject_o <= 1'b0;
         case (mstate)
            M_IDLE: if (s) begin
               mstate <= M_MEAS;
               width  <= 8'd1;
            end
            M_MEAS: if (s) begin
               if (width >= 8'(MAX_W)) begin
                  mstate   <= M_JAM;
                  reject_o <= 1'b1;
                  width    <= 8'(MAX_W + 1);
               end else begin
                  width <= width + 8'd1;
               end
            end else begin
               accept_o <= accept;
               reject_o <= !accept;
               mstate   <= M_IDLE;
            end
            M_JAM: if (!s) mstate <= M_IDLE;
            default: mstate <= M_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dstate <= D_IDLE;
         gap    <= 4'd0;
         coin_o <= 1'b0;
      end else begin
         coin_o <= 1'b0;
         case (dstate)
            D_IDLE: if (dispense) begin
               coin_o <= 1'b1;
               if (GAP > 0) begin
                  dstate <= D_WAIT;
                  gap    <= 4'(GAP);
               end
            end
            D_WAIT: begin
               gap <= gap - 4'd1;
               if (gap <= 4'd1) dstate <= D_IDLE;
            end
            default: dstate <= D_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         credit_o <= 8'd0;
         total_o  <= 8'd0;
      end else begin
         credit_o <= credit_o + {7'd0, accept} - {7'd0, dispense};
         if (accept) total_o <= total_o + 8'd1;
      end
   end

endmodule
